// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: eight-channel TDM transmitter. Captures SW[7:0] at frame start
// and sends one channel per slot on LEDR[0] with slot index, frame sync, busy
// and a 4-bit completed-frame counter. All LEDR bits come straight from flops.
module tdm_mux8_tx #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic [8:0] SW,
    output logic [9:0] LEDR
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shadow;
    logic [7:0]    w_shadow_nxt;
    logic [2:0]    r_slot;
    logic [2:0]    w_slot_nxt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] w_div_nxt;
    logic [3:0]    r_frame;
    logic [3:0]    w_frame_nxt;
    logic [9:0]    r_ledr;
    logic [9:0]    w_ledr_nxt;

    // State and datapath registers, cleared asynchronously by KEY.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_slot   <= '0;
            r_div    <= '0;
            r_frame  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_slot   <= w_slot_nxt;
            r_div    <= w_div_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    // Next-state logic: start on enable, advance slots every DIV clocks,
    // re-arm or stop at the last clock of slot 7.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_slot_nxt   = r_slot;
        w_div_nxt    = r_div;
        w_frame_nxt  = r_frame;
        case (r_state)
            S_IDLE: begin
                if (SW[8]) begin
                    w_state_nxt  = S_SEND;
                    w_shadow_nxt = SW[7:0];
                    w_slot_nxt   = '0;
                    w_div_nxt    = '0;
                end
            end
            S_SEND: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_slot != 3'd7) begin
                        w_slot_nxt = r_slot + 3'd1;
                    end else begin
                        w_frame_nxt = r_frame + 4'd1;
                        w_slot_nxt  = '0;
                        if (SW[8]) begin
                            w_shadow_nxt = SW[7:0];
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so LEDR can be registered without
    // adding a clock of latency.
    always_comb begin
        w_ledr_nxt      = '0;
        w_ledr_nxt[9:6] = w_frame_nxt;
        if (w_state_nxt == S_SEND) begin
            w_ledr_nxt[0]   = w_shadow_nxt[w_slot_nxt];
            w_ledr_nxt[1]   = (w_slot_nxt == 3'd0);
            w_ledr_nxt[4:2] = w_slot_nxt;
            w_ledr_nxt[5]   = 1'b1;
        end
    end

    // Output register.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_ledr <= '0;
        end else begin
            r_ledr <= w_ledr_nxt;
        end
    end

    assign LEDR = r_ledr;

endmodule
